// File: rtl/lane_writeback_pkg.sv
// Shared types for the per-lane write-back stage.
package lane_writeback_pkg;

    localparam int unsigned ThreadW = 4;
    localparam int unsigned RegW    = 4;
    localparam int unsigned DataW   = 18;

    // Integer pipe output: carries its own destination.
    typedef struct packed {
        logic [ThreadW-1:0] thread_num;
        logic [RegW-1:0]    rd;
        logic [DataW-1:0]   write_data;
        logic               regwrite;
        logic               set_pred;
        logic               new_pred_val;
    } int_write_reg;

    // FP pipe output: destination comes from the issue-time tag instead.
    typedef struct packed {
        logic [DataW-1:0] write_data;
        logic             regwrite;
        logic             set_pred;
        logic             new_pred_val;
    } fp_write_reg;

    typedef struct packed {
        logic               valid;
        logic [ThreadW-1:0] thread_num;
        logic [RegW-1:0]    rd;
    } wb_tag;

    typedef struct packed {
        logic [ThreadW-1:0] thread_num;
        logic [RegW-1:0]    rd;
        logic [DataW-1:0]   write_data;
        logic               regwrite;
        logic               set_pred;
        logic               new_pred_val;
    } wb_req;

    // An item only competes for the write port if it writes something.
    function automatic logic wants_write(input logic regwrite, input logic set_pred);
        return regwrite | set_pred;
    endfunction

endpackage

// File: rtl/lane_writeback_if.sv
// Bundle of issue tags, pipe results and write-port outputs of lane_writeback.
interface lane_writeback_if;
    import lane_writeback_pkg::*;

    logic               fp_issue_valid;
    logic [ThreadW-1:0] fp_issue_thread;
    logic [RegW-1:0]    fp_issue_rd;
    logic               int_wb_valid;
    int_write_reg       int_wb;
    logic               fp_wb_valid;
    fp_write_reg        fp_wb;
    logic               rf_we;
    logic [ThreadW-1:0] rf_thread;
    logic [RegW-1:0]    rf_addr;
    logic [DataW-1:0]   rf_wdata;
    logic               pred_we;
    logic [ThreadW-1:0] pred_thread;
    logic               pred_val;
    logic               stall_issue;
    logic               err_fp_tag;
    logic               err_ovf;

    modport master (
        output fp_issue_valid, fp_issue_thread, fp_issue_rd,
        output int_wb_valid, int_wb, fp_wb_valid, fp_wb,
        input  rf_we, rf_thread, rf_addr, rf_wdata, pred_we, pred_thread, pred_val,
        input  stall_issue, err_fp_tag, err_ovf
    );

    modport slave (
        input  fp_issue_valid, fp_issue_thread, fp_issue_rd,
        input  int_wb_valid, int_wb, fp_wb_valid, fp_wb,
        output rf_we, rf_thread, rf_addr, rf_wdata, pred_we, pred_thread, pred_val,
        output stall_issue, err_fp_tag, err_ovf
    );

endinterface

// File: rtl/lane_writeback_wb_fifo.sv
// Collision queue for integer results that lost write-port arbitration.
module lane_writeback_wb_fifo
    import lane_writeback_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  wb_req                  data_i,
    input  logic                   pop_i,
    output wb_req                  data_o,
    output logic [$clog2(Depth):0] count_next_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    wb_req           mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push_ok, pop_ok;

    assign full_o  = (count_q == FullCnt);
    assign empty_o = (count_q == '0);
    // Push while full is accepted only when the head leaves in the same cycle.
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_next_o = count_d;

    // Pointer and occupancy next state; pointers wrap at Depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PtrW'(push_ok);
        rd_ptr_d = rd_ptr_q + PtrW'(pop_ok);
        count_d  = count_q + CntW'(push_ok) - CntW'(pop_ok);
    end

    // Entry storage, no reset needed since occupancy gates reads.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointer and count state with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/lane_writeback.sv
// Per-lane write-back: merges FP and integer results onto one RF/predicate port.
module lane_writeback
    import lane_writeback_pkg::*;
#(
    parameter int unsigned FP_LATENCY   = 4,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STALL_MARGIN = 2
) (
    input logic             clk,
    input logic             rst_n,
    lane_writeback_if.slave bus
);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CntW-1:0] StallThr = CntW'(FIFO_DEPTH - STALL_MARGIN);

    wb_tag tag_q [FP_LATENCY];
    wb_tag tag_d [FP_LATENCY];
    wb_tag tail;

    logic            fp_req, int_req, bypass, push_req, int_drop, fp_tag_err;
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty, win_valid, waw_hit;
    logic [CntW-1:0] count_next;
    wb_req           int_as_req, fp_as_req, head, win;

    logic               rf_we_q, pred_we_q, pred_val_q, stall_q, err_fp_q, err_ovf_q;
    logic [ThreadW-1:0] thread_q;
    logic [RegW-1:0]    addr_q;
    logic [DataW-1:0]   wdata_q;

    // FP destination tag enters at issue and reaches the tail FP_LATENCY cycles later.
    assign tag_d[0] = {bus.fp_issue_valid, bus.fp_issue_thread, bus.fp_issue_rd};
    for (genvar g = 1; g < FP_LATENCY; g++) begin : g_shift
        assign tag_d[g] = tag_q[g-1];
    end
    assign tail = tag_q[FP_LATENCY-1];

    // Tag delay line; reset discards every in-flight tag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_q <= '{default: '0};
        end else begin
            tag_q <= tag_d;
        end
    end

    assign int_as_req = '{thread_num: bus.int_wb.thread_num, rd: bus.int_wb.rd,
                          write_data: bus.int_wb.write_data, regwrite: bus.int_wb.regwrite,
                          set_pred: bus.int_wb.set_pred, new_pred_val: bus.int_wb.new_pred_val};
    assign fp_as_req  = '{thread_num: tail.thread_num, rd: tail.rd,
                          write_data: bus.fp_wb.write_data, regwrite: bus.fp_wb.regwrite,
                          set_pred: bus.fp_wb.set_pred, new_pred_val: bus.fp_wb.new_pred_val};

    // Fixed priority: FP, then FIFO head, then int bypass when the FIFO is empty.
    always_comb begin
        fp_req     = bus.fp_wb_valid & tail.valid
                   & wants_write(bus.fp_wb.regwrite, bus.fp_wb.set_pred);
        int_req    = bus.int_wb_valid & wants_write(bus.int_wb.regwrite, bus.int_wb.set_pred);
        fp_tag_err = bus.fp_wb_valid ^ tail.valid;
        fifo_pop   = ~fp_req & ~fifo_empty;
        bypass     = ~fp_req & fifo_empty & int_req;
        push_req   = int_req & ~bypass;
        fifo_push  = push_req & (~fifo_full | fifo_pop);
        int_drop   = push_req & fifo_full & ~fifo_pop;
        win_valid  = fp_req | fifo_pop | bypass;
        if (fp_req) begin
            win = fp_as_req;
        end else if (fifo_pop) begin
            win = head;
        end else begin
            win = int_as_req;
        end
        waw_hit = fp_req & int_req & bus.fp_wb.regwrite & bus.int_wb.regwrite
                & (tail.thread_num == bus.int_wb.thread_num) & (tail.rd == bus.int_wb.rd);
    end

    lane_writeback_wb_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_wb_fifo (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .push_i       (fifo_push),
        .data_i       (int_as_req),
        .pop_i        (fifo_pop),
        .data_o       (head),
        .count_next_o (count_next),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    // Registered write port; data fields hold their value when nothing wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we_q    <= 1'b0;
            pred_we_q  <= 1'b0;
            pred_val_q <= 1'b0;
            thread_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            stall_q    <= 1'b0;
            err_fp_q   <= 1'b0;
            err_ovf_q  <= 1'b0;
        end else begin
            rf_we_q   <= win_valid & win.regwrite;
            pred_we_q <= win_valid & win.set_pred;
            if (win_valid) begin
                thread_q   <= win.thread_num;
                addr_q     <= win.rd;
                wdata_q    <= win.write_data;
                pred_val_q <= win.new_pred_val;
            end
            stall_q   <= (count_next >= StallThr);
            err_fp_q  <= err_fp_q | fp_tag_err;
            err_ovf_q <= err_ovf_q | int_drop;
        end
    end

    assign bus.rf_we       = rf_we_q;
    assign bus.rf_thread   = thread_q;
    assign bus.rf_addr     = addr_q;
    assign bus.rf_wdata    = wdata_q;
    assign bus.pred_we     = pred_we_q;
    assign bus.pred_thread = thread_q;
    assign bus.pred_val    = pred_val_q;
    assign bus.stall_issue = stall_q;
    assign bus.err_fp_tag  = err_fp_q;
    assign bus.err_ovf     = err_ovf_q;

    // Upstream scoreboard must never let an int and FP write hit the same register together.
    a_no_waw: assert property (@(posedge clk) disable iff (!rst_n) !waw_hit);

endmodule

// File: tb/tb_lane_writeback.sv
// Self-checking bench for lane_writeback: directed scenarios plus a random run
// checked against a queue-based reference model.
module tb_lane_writeback;
    import lane_writeback_pkg::*;

    localparam int unsigned L = 4;
    localparam int unsigned D = 4;
    localparam int unsigned M = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lane_writeback_if lw();

    lane_writeback #(
        .FP_LATENCY   (L),
        .FIFO_DEPTH   (D),
        .STALL_MARGIN (M)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (lw.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state: outstanding FP tags with due cycle, pending ints in order.
    typedef struct {
        logic [3:0] t;
        logic [3:0] rd;
        int         due;
    } tag_t;
    tag_t  tq[$];
    wb_req iq[$];

    logic        e_rf_we = 0, e_pred_we = 0, e_pred_val = 0, e_stall = 0;
    logic        e_err_fp = 0, e_err_ovf = 0;
    logic [3:0]  e_thread = 0, e_addr = 0;
    logic [17:0] e_wdata = 0;

    task automatic idle();
        lw.fp_issue_valid  = 1'b0;
        lw.fp_issue_thread = '0;
        lw.fp_issue_rd     = '0;
        lw.int_wb_valid    = 1'b0;
        lw.int_wb          = '0;
        lw.fp_wb_valid     = 1'b0;
        lw.fp_wb           = '0;
    endtask

    task automatic put_int(input logic [3:0] tt, input logic [3:0] tr, input logic [17:0] d,
                           input logic rw, input logic sp, input logic pv);
        lw.int_wb_valid = 1'b1;
        lw.int_wb = '{thread_num: tt, rd: tr, write_data: d, regwrite: rw, set_pred: sp,
                      new_pred_val: pv};
    endtask

    task automatic put_fp(input logic [17:0] d);
        lw.fp_wb_valid = 1'b1;
        lw.fp_wb = '{write_data: d, regwrite: 1'b1, set_pred: 1'b0, new_pred_val: 1'b0};
    endtask

    task automatic issue(input logic [3:0] tt, input logic [3:0] tr);
        lw.fp_issue_valid  = 1'b1;
        lw.fp_issue_thread = tt;
        lw.fp_issue_rd     = tr;
    endtask

    // Advance the model with the current inputs, then clock the DUT and settle.
    task automatic tick();
        logic       hit, fp_req, int_req, win, granted;
        logic [3:0] ht, hr;
        wb_req      w, ir;
        if (!rst_n) begin
            tq.delete();
            iq.delete();
            {e_rf_we, e_pred_we, e_pred_val, e_stall, e_err_fp, e_err_ovf} = '0;
            e_thread = '0;
            e_addr   = '0;
            e_wdata  = '0;
        end else begin
            hit = 1'b0;
            ht  = '0;
            hr  = '0;
            if (tq.size() > 0 && tq[0].due == cyc) begin
                hit = 1'b1;
                ht  = tq[0].t;
                hr  = tq[0].rd;
                tq.delete(0);
            end
            if (lw.fp_issue_valid)
                tq.push_back('{t: lw.fp_issue_thread, rd: lw.fp_issue_rd, due: cyc + L});
            if (lw.fp_wb_valid != hit) e_err_fp = 1'b1;
            fp_req = lw.fp_wb_valid && hit && (lw.fp_wb.regwrite || lw.fp_wb.set_pred);
            ir = '{thread_num: lw.int_wb.thread_num, rd: lw.int_wb.rd,
                   write_data: lw.int_wb.write_data, regwrite: lw.int_wb.regwrite,
                   set_pred: lw.int_wb.set_pred, new_pred_val: lw.int_wb.new_pred_val};
            int_req = lw.int_wb_valid && (ir.regwrite || ir.set_pred);
            win     = 1'b0;
            granted = 1'b0;
            w       = ir;
            if (fp_req) begin
                win = 1'b1;
                w = '{thread_num: ht, rd: hr, write_data: lw.fp_wb.write_data,
                      regwrite: lw.fp_wb.regwrite, set_pred: lw.fp_wb.set_pred,
                      new_pred_val: lw.fp_wb.new_pred_val};
            end else if (iq.size() > 0) begin
                win = 1'b1;
                w   = iq.pop_front();
            end else if (int_req) begin
                win     = 1'b1;
                granted = 1'b1;
            end
            if (int_req && !granted) begin
                if (iq.size() >= D) e_err_ovf = 1'b1;
                else iq.push_back(ir);
            end
            e_rf_we   = win && w.regwrite;
            e_pred_we = win && w.set_pred;
            if (win) begin
                e_thread   = w.thread_num;
                e_addr     = w.rd;
                e_wdata    = w.write_data;
                e_pred_val = w.new_pred_val;
            end
            e_stall = (iq.size() >= D - M);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        logic [35:0] obs;
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        obs = {lw.rf_we, lw.pred_we, lw.rf_thread, lw.rf_addr, lw.rf_wdata, lw.pred_thread,
               lw.pred_val, lw.stall_issue, lw.err_fp_tag, lw.err_ovf};
        n_checks++;
        if (obs !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", obs);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_int_only();
        idle();
        put_int(4'd3, 4'd5, 18'h1ABCD, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        n_checks++;
        if ({lw.rf_we, lw.pred_we, lw.rf_thread, lw.rf_addr, lw.rf_wdata, lw.stall_issue}
            !== {1'b1, 1'b0, 4'd3, 4'd5, 18'h1ABCD, 1'b0}) begin
            n_fail++;
            $display("FAIL int_only: got we=%b t=%0d a=%0d d=%h st=%b expected 1/3/5/1abcd/0",
                     lw.rf_we, lw.rf_thread, lw.rf_addr, lw.rf_wdata, lw.stall_issue);
        end
        tick();
        n_checks++;
        if ({lw.rf_we, lw.rf_wdata} !== {1'b0, 18'h1ABCD}) begin
            n_fail++;
            $display("FAIL int_hold: got we=%b d=%h expected 0/1abcd", lw.rf_we, lw.rf_wdata);
        end
    endtask

    task automatic test_fp_latency();
        idle();
        issue(4'd2, 4'd7);
        tick();
        idle();
        for (int i = 1; i < 4; i++) begin
            tick();
            n_checks++;
            if (lw.rf_we !== 1'b0) begin
                n_fail++;
                $display("FAIL fp_early_write c%0d: got %b expected 0", i, lw.rf_we);
            end
        end
        put_fp(18'h00042);
        tick();
        idle();
        n_checks++;
        if ({lw.rf_we, lw.rf_thread, lw.rf_addr, lw.rf_wdata, lw.err_fp_tag}
            !== {1'b1, 4'd2, 4'd7, 18'h00042, 1'b0}) begin
            n_fail++;
            $display("FAIL fp_latency: got we=%b t=%0d a=%0d d=%h err=%b expected 1/2/7/42/0",
                     lw.rf_we, lw.rf_thread, lw.rf_addr, lw.rf_wdata, lw.err_fp_tag);
        end
    endtask

    task automatic test_collision();
        logic [26:0] exp_w [3];
        exp_w[0] = {1'b1, 4'd2, 4'd2, 18'h0B0B0};
        exp_w[1] = {1'b1, 4'd1, 4'd1, 18'h0A0A0};
        exp_w[2] = {1'b1, 4'd3, 4'd4, 18'h0C0C0};
        idle();
        issue(4'd2, 4'd2);
        tick();
        idle();
        repeat (3) tick();
        put_int(4'd1, 4'd1, 18'h0A0A0, 1'b1, 1'b0, 1'b0);
        put_fp(18'h0B0B0);
        for (int k = 0; k < 3; k++) begin
            tick();
            idle();
            if (k == 0) put_int(4'd3, 4'd4, 18'h0C0C0, 1'b1, 1'b0, 1'b0);
            n_checks++;
            if ({lw.rf_we, lw.rf_thread, lw.rf_addr, lw.rf_wdata} !== exp_w[k]) begin
                n_fail++;
                $display("FAIL collision_order[%0d]: got %h expected %h", k,
                         {lw.rf_we, lw.rf_thread, lw.rf_addr, lw.rf_wdata}, exp_w[k]);
            end
        end
        tick();
        n_checks++;
        if (lw.rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_idle: got rf_we=%b expected 0", lw.rf_we);
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] d;
        for (int c = 0; c < 9; c++) begin
            idle();
            if (c < 5) issue(4'(c), 4'(8 + c));
            if (c >= 4) begin
                put_fp(18'(32'h200 + c - 4));
                put_int(4'(c - 4), 4'(c - 4), 18'(32'h100 + c - 4), 1'b1, 1'b0, 1'b0);
            end
            tick();
            if (c >= 4) begin
                d = 18'(32'h200 + c - 4);
                n_checks++;
                if ({lw.rf_we, lw.rf_wdata} !== {1'b1, d}) begin
                    n_fail++;
                    $display("FAIL b2b_fp[%0d]: got %b/%h expected 1/%h", c, lw.rf_we,
                             lw.rf_wdata, d);
                end
            end
            if (c == 4 || c == 5) begin
                n_checks++;
                if (lw.stall_issue !== (c == 5)) begin
                    n_fail++;
                    $display("FAIL b2b_stall c%0d: got %b expected %b", c, lw.stall_issue,
                             (c == 5));
                end
            end
            if (c == 7 || c == 8) begin
                n_checks++;
                if (lw.err_ovf !== (c == 8)) begin
                    n_fail++;
                    $display("FAIL b2b_ovf c%0d: got %b expected %b", c, lw.err_ovf, (c == 8));
                end
            end
        end
        idle();
        for (int k = 0; k < 4; k++) begin
            tick();
            d = 18'(32'h100 + k);
            n_checks++;
            if ({lw.rf_we, lw.rf_thread, lw.rf_wdata} !== {1'b1, 4'(k), d}) begin
                n_fail++;
                $display("FAIL b2b_int_order[%0d]: got %b/%0d/%h expected 1/%0d/%h", k,
                         lw.rf_we, lw.rf_thread, lw.rf_wdata, k, d);
            end
        end
        tick();
        n_checks++;
        if ({lw.rf_we, lw.stall_issue} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_drained: got we=%b stall=%b expected 0/0", lw.rf_we,
                     lw.stall_issue);
        end
    endtask

    task automatic test_predicate();
        idle();
        put_int(4'd4, 4'd6, 18'h00000, 1'b0, 1'b1, 1'b1);
        tick();
        idle();
        n_checks++;
        if ({lw.pred_we, lw.pred_val, lw.rf_we, lw.pred_thread} !== {1'b1, 1'b1, 1'b0, 4'd4})
        begin
            n_fail++;
            $display("FAIL predicate: got pwe=%b pv=%b rwe=%b pt=%0d expected 1/1/0/4",
                     lw.pred_we, lw.pred_val, lw.rf_we, lw.pred_thread);
        end
    endtask

    task automatic test_tag_error_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 7; c++) begin
            idle();
            if (c < 4) issue(4'(c), 4'(8 + c));
            if (c == 3) put_fp(18'h3FFFF);
            if (c >= 4) begin
                put_fp(18'(32'h300 + c));
                put_int(4'(c), 4'(c - 4), 18'(32'h50 + c), 1'b1, 1'b0, 1'b0);
            end
            tick();
            if (c == 3) begin
                n_checks++;
                if ({lw.err_fp_tag, lw.rf_we} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL tag_error: got err=%b we=%b expected 1/0", lw.err_fp_tag,
                             lw.rf_we);
                end
            end
        end
        n_checks++;
        if (lw.stall_issue !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_stall: got %b expected 1", lw.stall_issue);
        end
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if ({lw.stall_issue, lw.err_fp_tag, lw.err_ovf, lw.rf_we, lw.pred_we} !== 5'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got st/efp/eovf/we/pwe=%b expected 00000",
                     {lw.stall_issue, lw.err_fp_tag, lw.err_ovf, lw.rf_we, lw.pred_we});
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            n_checks++;
            if ({lw.rf_we, lw.pred_we, lw.err_fp_tag, lw.stall_issue} !== 4'b0) begin
                n_fail++;
                $display("FAIL stale_after_reset[%0d]: got we/pwe/efp/st=%b expected 0000", k,
                         {lw.rf_we, lw.pred_we, lw.err_fp_tag, lw.stall_issue});
            end
        end
    endtask

    task automatic test_random();
        logic [35:0] obs, exp_v;
        logic        due;
        for (int n = 0; n < 600; n++) begin
            idle();
            rst_n = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 2) == 0) issue(4'($urandom_range(0, 15)), 4'($urandom_range(8, 15)));
            due = (tq.size() > 0 && tq[0].due == cyc);
            if ($urandom_range(0, 63) == 0) due = ~due;
            if (due) begin
                lw.fp_wb_valid = 1'b1;
                lw.fp_wb = '{write_data: 18'($urandom), regwrite: ($urandom_range(0, 3) != 0),
                             set_pred: 1'($urandom), new_pred_val: 1'($urandom)};
            end
            if ($urandom_range(0, 1) == 1)
                put_int(4'($urandom_range(0, 15)), 4'($urandom_range(0, 7)), 18'($urandom),
                        1'($urandom), 1'($urandom), 1'($urandom));
            tick();
            obs   = {lw.rf_we, lw.pred_we, lw.rf_thread, lw.rf_addr, lw.rf_wdata,
                     lw.pred_thread, lw.pred_val, lw.stall_issue, lw.err_fp_tag, lw.err_ovf};
            exp_v = {e_rf_we, e_pred_we, e_thread, e_addr, e_wdata, e_thread, e_pred_val,
                     e_stall, e_err_fp, e_err_ovf};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h expected %h", n, obs, exp_v);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        test_reset();
        test_int_only();
        test_fp_latency();
        test_collision();
        test_back_to_back();
        test_predicate();
        test_tag_error_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
